// File: rtl/scan_response_misr.sv
// Scan-unload sequencer and MISR response compactor: drives SE/CAPT for
// NPAT capture+unload rounds, folds SO into a Galois MISR, then compares against GOLD.
module scan_response_misr #(
  parameter int unsigned       NCHAIN    = 4,
  parameter int unsigned       CHAIN_LEN = 16,
  parameter int unsigned       MISR_W    = 16,
  parameter logic [MISR_W-1:0] POLY      = MISR_W'(16'h1021),
  parameter int unsigned       PAT_W     = 8
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              START,
  input  logic [PAT_W-1:0]  NPAT,
  input  logic [MISR_W-1:0] SEED,
  input  logic [MISR_W-1:0] GOLD,
  input  logic [NCHAIN-1:0] SO,
  output logic              SE,
  output logic              CAPT,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIG
);

  localparam int unsigned    SH_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_SHIFT, S_CMP} state_t;

  state_t            r_state;
  logic [PAT_W-1:0]  r_pat_cnt;
  logic [SH_W-1:0]   r_shift_cnt;
  logic [MISR_W-1:0] r_misr;
  logic              r_se;
  logic              r_capt;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic [MISR_W-1:0] w_misr_next;
  logic [PAT_W-1:0]  w_pat_dec;

  // Galois left shift with polynomial feedback; chain i folds into bit i
  assign w_misr_next = {r_misr[MISR_W-2:0], 1'b0}
                     ^ (r_misr[MISR_W-1] ? POLY : '0)
                     ^ MISR_W'(SO);
  assign w_pat_dec   = r_pat_cnt - PAT_W'(1);

  // Session FSM; every output is set from the state being entered
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state     <= S_IDLE;
      r_pat_cnt   <= '0;
      r_shift_cnt <= '0;
      r_misr      <= '0;
      r_se        <= 1'b0;
      r_capt      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_capt <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_pat_cnt <= NPAT;
            r_misr    <= SEED;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
            if (NPAT != '0) begin
              r_state <= S_CAPT;
              r_capt  <= 1'b1;
            end else begin
              r_state <= S_CMP;
            end
          end
        end
        S_CAPT: begin
          r_state     <= S_SHIFT;
          r_se        <= 1'b1;
          r_shift_cnt <= '0;
        end
        S_SHIFT: begin
          r_misr <= w_misr_next;
          if (r_shift_cnt == SH_LAST) begin
            r_pat_cnt   <= w_pat_dec;
            r_shift_cnt <= '0;
            r_se        <= 1'b0;
            if (w_pat_dec != '0) begin
              r_state <= S_CAPT;
              r_capt  <= 1'b1;
            end else begin
              r_state <= S_CMP;
            end
          end else begin
            r_shift_cnt <= r_shift_cnt + SH_W'(1);
          end
        end
        S_CMP: begin
          r_pass  <= (r_misr == GOLD);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_se    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign SE   = r_se;
  assign CAPT = r_capt;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign PASS = r_pass;
  assign SIG  = r_misr;

endmodule

// File: tb/tb_scan_response_misr.sv
// Scoreboard bench for scan_response_misr: expected signature/PASS pushed at
// START, popped on DONE; per-cycle SE/CAPT/BUSY/DONE schedule and SIG tracking.
module tb_scan_response_misr;

  localparam int unsigned L = 16;

  logic        CLK = 1'b0;
  logic        RSTB;
  logic        START;
  logic [7:0]  NPAT;
  logic [15:0] SEED;
  logic [15:0] GOLD;
  logic [3:0]  SO;
  logic        SE, CAPT, BUSY, DONE, PASS;
  logic [15:0] SIG;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  scan_response_misr dut (
    .CLK  (CLK),
    .RSTB (RSTB),
    .START(START),
    .NPAT (NPAT),
    .SEED (SEED),
    .GOLD (GOLD),
    .SO   (SO),
    .SE   (SE),
    .CAPT (CAPT),
    .BUSY (BUSY),
    .DONE (DONE),
    .PASS (PASS),
    .SIG  (SIG)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [3:0] s);
    logic [15:0] r;
    r = {m[14:0], 1'b0};
    if (m[15]) r = r ^ 16'h1021;
    return r ^ {12'h000, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // One complete session; leaves the caller in the DONE cycle
  task automatic run_session(input int n, input logic [15:0] seed, input logic [15:0] gold_xor,
                             input int kind, input bit glitch,
                             output int n_capt, output int n_se, output int n_done,
                             output logic [15:0] sig1, output logic [15:0] sig2,
                             output logic [15:0] fin_sig, output logic fin_pass);
    logic [3:0]  so_q[$];
    logic [3:0]  s;
    logic [15:0] m;
    logic [15:0] gold;
    exp_t        e;
    int          d;
    int          sched_err;
    int          sig_err;
    logic        ecapt, ese, ebusy, edone;
    n_capt = 0; n_se = 0; n_done = 0; sched_err = 0; sig_err = 0;
    sig1 = '0; sig2 = '0; fin_sig = '0; fin_pass = 1'b0;
    d = n * (L + 1) + 2;
    m = seed;
    for (int i = 0; i < n * int'(L); i++) begin
      if (kind == 1)                s = 4'($urandom);
      else if (kind == 2 && i == 0) s = 4'b0001;
      else                          s = 4'b0000;
      so_q.push_back(s);
      m = misr_step(m, s);
    end
    gold   = m ^ gold_xor;
    e.sig  = m;
    e.pass = (gold == m);
    sb_q.push_back(e);
    m = seed;
    START = 1'b1; NPAT = 8'(n); SEED = seed; GOLD = gold; SO = '0;
    step();
    for (int c = 1; c <= d; c++) begin
      if (c <= n * int'(L + 1)) begin
        ecapt = ((c - 1) % int'(L + 1)) == 0;
        ese   = !ecapt;
        ebusy = 1'b1;
        edone = 1'b0;
      end else begin
        ecapt = 1'b0;
        ese   = 1'b0;
        ebusy = (c == d - 1);
        edone = (c == d);
      end
      if ({SE, CAPT, BUSY, DONE} !== {ese, ecapt, ebusy, edone}) sched_err++;
      if (SIG !== m) sig_err++;
      n_capt += int'(CAPT);
      n_se   += int'(SE);
      if (c == 1) chk("pass_clear_on_start", 32'(PASS), 32'd0);
      if (c == 3) sig1 = SIG;
      if (c == 4) sig2 = SIG;
      if (DONE === 1'b1) begin
        n_done++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("sb_sig", 32'(SIG), 32'(e.sig));
          chk("sb_pass", 32'(PASS), 32'(e.pass));
        end else begin
          chk("sb_unexpected_done", 32'(sb_q.size()), 32'd1);
        end
      end
      fin_sig  = SIG;
      fin_pass = PASS;
      START = 1'b0; SO = '0;
      if (glitch && n > 0 && (c == 3 || c == d - 1)) begin
        START = 1'b1; NPAT = 8'd7; SEED = 16'h1234;
      end
      if (ese && so_q.size() > 0) begin
        SO = so_q.pop_front();
        m  = misr_step(m, SO);
      end
      if (c < d) step();
    end
    START = 1'b0;
    chk("schedule_se_capt_busy_done", 32'(sched_err), 32'd0);
    chk("sig_tracks_model", 32'(sig_err), 32'd0);
    chk("done_once", 32'(n_done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int          nc, ns, nd;
    logic [15:0] s1, s2, fs;
    logic        fp;
    int          bad;
    RSTB = 1'b0; START = 1'b0; NPAT = '0; SEED = '0; GOLD = '0; SO = '0;
    #3;
    chk("reset_outputs", {15'd0, SE, CAPT, BUSY, DONE, PASS, SIG}, 32'd0);
    #4 RSTB = 1'b1;
    step(); step();

    // Zero response
    run_session(1, 16'h0000, 16'h0000, 0, 1'b0, nc, ns, nd, s1, s2, fs, fp);
    chk("zero_sig", 32'(fs), 32'h0000);
    chk("zero_pass", 32'(fp), 32'd1);
    chk("zero_capt_cnt", 32'(nc), 32'd1);
    chk("zero_se_cnt", 32'(ns), 32'd16);
    step(); step();

    // Feedback from MSB
    run_session(1, 16'h8000, 16'h0000, 0, 1'b0, nc, ns, nd, s1, s2, fs, fp);
    chk("fb_msb_first_shift", 32'(s1), 32'h1021);
    step();

    // Single SO bit on first shift only
    run_session(1, 16'h0000, 16'h0000, 2, 1'b0, nc, ns, nd, s1, s2, fs, fp);
    chk("fb_so_first_shift", 32'(s1), 32'h0001);
    chk("fb_so_second_shift", 32'(s2), 32'h0002);
    step();

    // NPAT=0 match, then START in the DONE cycle with a mismatching GOLD
    run_session(0, 16'hBEEF, 16'h0000, 0, 1'b0, nc, ns, nd, s1, s2, fs, fp);
    chk("npat0_pass", 32'(fp), 32'd1);
    chk("npat0_sig", 32'(fs), 32'hBEEF);
    chk("npat0_no_activity", 32'(nc + ns), 32'd0);
    run_session(0, 16'hBEEF, 16'h0001, 0, 1'b0, nc, ns, nd, s1, s2, fs, fp);
    chk("npat0_mismatch_pass", 32'(fp), 32'd0);

    // Multi-pattern mismatch with ignored STARTs, chained from the DONE cycle
    run_session(3, 16'($urandom), 16'h0001, 1, 1'b1, nc, ns, nd, s1, s2, fs, fp);
    chk("multi_capt_cnt", 32'(nc), 32'd3);
    chk("multi_se_cnt", 32'(ns), 32'd48);
    chk("multi_pass", 32'(fp), 32'd0);
    step();

    // Full-range pattern count
    run_session(255, 16'($urandom), 16'h0000, 1, 1'b0, nc, ns, nd, s1, s2, fs, fp);
    chk("max_npat_capt_cnt", 32'(nc), 32'd255);
    chk("max_npat_pass", 32'(fp), 32'd1);
    step();

    // Asynchronous reset in the middle of pattern 2's unload
    START = 1'b1; NPAT = 8'd3; SEED = 16'h5A5A; GOLD = 16'h0000;
    step();
    START = 1'b0;
    for (int c = 1; c < 23; c++) begin
      SO = 4'($urandom);
      step();
    end
    chk("pre_reset_in_shift", 32'({SE, BUSY}), 32'd3);
    #3 RSTB = 1'b0;
    #1 chk("async_reset_outputs", {15'd0, SE, CAPT, BUSY, DONE, PASS, SIG}, 32'd0);
    step(); step();
    #3 RSTB = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if ({SE, CAPT, BUSY, DONE} !== 4'b0000) bad++;
    end
    chk("idle_after_reset", 32'(bad), 32'd0);
    run_session(2, 16'hC3A5, 16'h0000, 1, 1'b0, nc, ns, nd, s1, s2, fs, fp);
    chk("post_reset_pass", 32'(fp), 32'd1);
    chk("post_reset_capt_cnt", 32'(nc), 32'd2);
    step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
